// File: rtl/kbd_fifo_mmio.sv
// kbd_fifo_mmio: PS/2 scan-code FIFO with optional break-code filter,
// read and controlled by the CPU through a four-byte register window.
module kbd_fifo_mmio #(
  parameter int              DEPTH          = 16,
  parameter int              AW             = 16,
  parameter logic [AW-1:0]   BASE           = 16'hFFA0,
  parameter bit              FILTER_DEFAULT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_hit,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic          wren,
  output logic [7:0]    rdata,
  output logic          sel,
  output logic          irq
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, SKIP} state_t;
  state_t        r_state, w_state_nx;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic [7:0]    r_total;
  logic          r_ovf, r_filt;
  logic          w_we, w_pop_wr, w_ctrl, w_flush, w_empty, w_full;
  logic          w_cand, w_push, w_pop, w_ovf_set;
  assign sel       = addr[AW-1:2] == BASE[AW-1:2];
  assign w_we      = sel & wren;
  assign w_pop_wr  = w_we & (addr[1:0] == 2'd0);
  assign w_ctrl    = w_we & (addr[1:0] == 2'd2);
  assign w_flush   = w_ctrl & wdata[0];
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == (PW+1)'(DEPTH);
  assign w_cand    = ps2_hit & (~r_filt | (r_state == IDLE && ps2_data != 8'hF0));
  assign w_pop     = w_pop_wr & ~w_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign w_push    = w_cand & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_cand & ~w_flush & w_full & ~w_pop;
  assign irq       = ~w_empty;
  always_comb begin
    w_state_nx = (~r_filt | (w_ctrl & ~wdata[2])) ? IDLE :
                 ~ps2_hit ? r_state :
                 (r_state == IDLE && ps2_data == 8'hF0) ? SKIP : IDLE;
  end
  assign rdata = (addr[1:0] == 2'd0) ? (w_empty ? 8'h00 : r_mem[r_head]) :
                 (addr[1:0] == 2'd1) ? 8'(r_count) :
                 (addr[1:0] == 2'd2) ? {4'b0, r_filt, r_ovf, w_full, w_empty} :
                 r_total;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_filt  <= FILTER_DEFAULT;
      r_ovf   <= 1'b0;
      r_total <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_ctrl) r_filt <= wdata[2];
      r_ovf   <= (r_ovf & ~(w_ctrl & wdata[1])) | w_ovf_set;
      r_total <= (w_we && addr[1:0] == 2'd3) ? '0 : r_total + {7'b0, w_push};
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop) r_head <= r_head + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= ps2_data;
  end
endmodule

// File: doc/kbd_fifo_mmio.md
# kbd_fifo_mmio

Memory-mapped PS/2 scan-code receiver that replaces the single-byte keyboard latch and press counter at the top-level memory controller. Received scan codes are buffered in a parametrised FIFO with optional break-code filtering, and the CPU reads them through a four-byte register window. The block sits between `ps2keyboard` and the CPU bus, and drives the shared `i_data` mux through `rdata` and `sel`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..128.
- `AW`, 16: bus address width.
- `BASE`, 16'hFFA0: base address of the register window; must be 4-byte aligned.
- `FILTER_DEFAULT`, 0: reset value of the filter-enable bit.

- `clk`  in  1: single clock; the bus and the keyboard strobe are both synchronous to it.
- `rst`  in  1: asynchronous, active-high reset.
- `ps2_data`  in  8: scan code from `ps2keyboard`.
- `ps2_hit`  in  1: one-cycle strobe meaning `ps2_data` is valid.
- `addr`  in  AW: CPU address.
- `wdata`  in  8: CPU write data.
- `wren`  in  1: CPU write strobe; one write per asserted cycle.
- `rdata`  out  8: register read data; combinational from `addr` and internal state.
- `sel`  out  1: high when `addr[AW-1:2] == BASE[AW-1:2]`; used by the top-level mux.
- `irq`  out  1: high when the FIFO is not empty.

## Operation
Register map, at offset `addr[1:0]`:
- **+0 DATA**
  - Read: head byte, or 0x00 when the FIFO is empty.
  - Write (any value): pop one entry. Ignored when empty.
- **+1 COUNT**
  - Read: occupancy, zero-extended to 8 bits.
  - Write: ignored.
- **+2 STATUS / CTRL**
  - Read bits: [0] empty, [1] full, [2] overflow (sticky), [3] filter_en, [7:4] = 0.
  - Write bits:
    - [0]=1: flush (head, tail and count go to 0).
    - [1]=1: clear overflow.
    - [2]: loads filter_en.
- **+3 TOTAL**
  - Read: 8-bit wrapping count of bytes pushed since reset.
  - Write: clears TOTAL to 0.

Writes take effect only when `sel & wren`.

Filter FSM, with states IDLE and SKIP:
- filter_en=0: every `ps2_hit` byte is a push candidate. The FSM is held in IDLE.
- filter_en=1, IDLE:
  - byte 0xF0: dropped, go to SKIP.
  - any other byte, including 0xE0: push candidate.
- filter_en=1, SKIP: the byte is dropped and the FSM returns to IDLE.
- Writing filter_en=0 forces IDLE on the next edge.

Push rules:
- Push candidate while not full: written at tail, count+1, TOTAL+1.
- Push candidate while full with no pop in the same cycle: byte dropped, overflow set, TOTAL unchanged.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This holds even when full; no overflow is flagged.
  - When empty, only the push takes effect.

Flush:
- Flush in the same cycle as a push: flush wins. The byte is discarded, overflow is unaffected and TOTAL does not increment.
- Flush and clear-overflow may be combined in a single write.

Other rules:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Storage is a register array with an asynchronous read of the head.

## Timing
- Reset values:
  - Head, tail, count, TOTAL and overflow: 0.
  - FSM: IDLE.
  - filter_en: FILTER_DEFAULT.
  - `irq`: 0. `rdata` reads 0x00 at DATA, 0x00 at COUNT, {4'b0, FILTER_DEFAULT, 3'b001} at STATUS, and 0x00 at TOTAL.
  - FIFO storage contents: don't-care.
- Push latency: with `ps2_hit` in cycle N, the byte is visible at DATA, COUNT, TOTAL and `irq` from cycle N+1.
- Pop: a write to DATA at edge N means DATA shows the next entry from N+1. `irq` falls at N+1 if the FIFO became empty.
- `rdata` and `sel` are purely combinational from `addr` and registers, with no wait states. The CPU samples in the same cycle.
- Assertion of `rst` at any time clears everything immediately; in-flight bytes are lost.

## Test plan
1. **Reset:** after reset, read +2 gives 0x01 (FILTER_DEFAULT=0) and `irq`=0. Push 0x1C, read +0 gives 0x1C, read +1 gives 0x01, `irq`=1. Write +0, then +1 reads 0x00 and `irq`=0.
2. **Fill and overflow (DEPTH=16):** push 0x00..0x0F, then +2 reads 0x02 (full). Push 0x10, then +2 reads 0x06 and TOTAL reads 0x10. Pop all 16 and confirm order 0x00..0x0F. Write +2 with 0x02, then +2 reads 0x01.
3. **Simultaneous push and pop while full:** push 0xAA in the same cycle as a DATA write. Count stays 16, overflow stays 0, the head becomes the second-oldest entry, and 0xAA exits last.
4. **Filter:** write +2 with 0x04, then push 0x1C, 0xF0, 0x1C, 0xE0, 0x75. The FIFO holds 0x1C, 0xE0, 0x75, and TOTAL reads 0x03. Push 0xF0, disable the filter, then push 0x1C: 0x1C is stored.
5. **Flush collision:** FIFO holds 3 entries. Write +2 with 0x01 in the same cycle as a push of 0x55. Count reads 0, overflow reads 0, TOTAL is unchanged.
6. **Wrap-around and mid-operation reset:** perform 40 interleaved push/pop pairs at DEPTH=16 and check order against a model. Assert `rst` with 5 entries queued: `irq` drops immediately and all registers return to their reset values.
